// File: rtl/rowunit_read_scheduler.sv
// Layered LDPC row-unit read scheduler: sweeps every layer's row addresses once per iteration,
// inserting a pipeline-drain gap between layers. Optional early termination via `EARLY_TERM_EN.
module rowunit_read_scheduler #(
  parameter int unsigned LAYERS     = 2,
  parameter int unsigned ADDRWIDTH  = 5,
  parameter int unsigned ADDRDEPTH  = 20,
  parameter int unsigned PIPESTAGES = 11,
  parameter int unsigned ITERW      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERW-1:0]     max_iter,
  input  logic                 parity_ok,
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic                 busy,
  output logic                 done,
  output logic [ITERW-1:0]     iter_count
);

  localparam int unsigned LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int unsigned GW = (PIPESTAGES > 1) ? $clog2(PIPESTAGES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state;
  logic [LW-1:0]    layer;
  logic [GW-1:0]    gap_cnt;
  logic [ITERW-1:0] max_q;

  logic             last_addr_c;
  logic             last_gap_c;
  logic             last_layer_c;
  logic [LW-1:0]    layer_inc_c;
  logic [ITERW-1:0] iter_next_c;
  logic             stop_c;

  // Iteration bookkeeping; the counter saturates rather than wrapping.
  always_comb begin
    last_addr_c  = (rdaddress == ADDRWIDTH'(ADDRDEPTH - 1));
    last_gap_c   = (gap_cnt == GW'(PIPESTAGES - 1));
    last_layer_c = (layer == LW'(LAYERS - 1));
    layer_inc_c  = layer + LW'(1);
    iter_next_c  = (iter_count == {ITERW{1'b1}}) ? iter_count : iter_count + ITERW'(1);
  end

`ifdef EARLY_TERM_EN
  always_comb stop_c = (iter_next_c == max_q) || parity_ok;
`else
  logic unused_parity_ok;
  assign unused_parity_ok = parity_ok;
  always_comb stop_c = (iter_next_c == max_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      layer      <= '0;
      gap_cnt    <= '0;
      max_q      <= '0;
      rdlayer    <= 1'b0;
      rdaddress  <= '0;
      rden_LLR   <= 1'b0;
      rden_E     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iter_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (max_iter != '0) begin
              state      <= READ;
              max_q      <= max_iter;
              iter_count <= '0;
              layer      <= '0;
              rdlayer    <= 1'b0;
              rdaddress  <= '0;
              rden_LLR   <= 1'b1;
              rden_E     <= 1'b0;
              busy       <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end

        READ: begin
          if (last_addr_c) begin
            state     <= GAP;
            gap_cnt   <= '0;
            rdaddress <= '0;
            rdlayer   <= 1'b0;
            rden_LLR  <= 1'b0;
            rden_E    <= 1'b0;
          end else begin
            rdaddress <= rdaddress + ADDRWIDTH'(1);
          end
        end

        // Read enables stay low while the previous layer's writeback drains.
        GAP: begin
          if (!last_gap_c) begin
            gap_cnt <= gap_cnt + GW'(1);
          end else if (!last_layer_c) begin
            state     <= READ;
            layer     <= layer_inc_c;
            rdlayer   <= 1'(layer_inc_c);
            rdaddress <= '0;
            rden_LLR  <= 1'b1;
            rden_E    <= (iter_count != '0);
          end else begin
            iter_count <= iter_next_c;
            layer      <= '0;
            if (stop_c) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= READ;
              rdlayer   <= 1'b0;
              rdaddress <= '0;
              rden_LLR  <= 1'b1;
              rden_E    <= (iter_next_c != '0);
            end
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
